// File: rtl/alu_issue_ctrl.sv
// Issue controller for a registered-latency ALU: accepts one instruction, launches
// operands from the internal register file, waits ALU_LAT edges, then writes back.
module alu_issue_ctrl #(
  parameter int W       = 32,
  parameter int REG_AW  = 4,
  parameter int ALU_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [REG_AW-1:0] instr_rd,
  input  logic [REG_AW-1:0] instr_rn,
  input  logic [REG_AW-1:0] instr_rm,
  input  logic              instr_use_imm,
  input  logic [W-1:0]      instr_imm,
  output logic [W-1:0]      alu_a,
  output logic [W-1:0]      alu_b,
  output logic [2:0]        alu_func,
  input  logic [W-1:0]      alu_result,
  input  logic [3:0]        alu_flags,
  output logic              done_valid,
  output logic [REG_AW-1:0] done_rd,
  output logic [W-1:0]      done_result,
  output logic              done_err,
  output logic [3:0]        flags_q,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [W-1:0]      dbg_data
);
  localparam int NREG = 1 << REG_AW;
  localparam int CW   = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(ALU_LAT - 1);
  localparam logic [2:0] OP_CMP = 3'b100;
  localparam logic [2:0] OP_ILL = 3'b111;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [REG_AW-1:0] rd_q;
  logic [2:0]        op_q;
  logic [W-1:0]      regs [NREG];
  logic              accept, wb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    wb        = 1'b0;
    case (state)
      IDLE: if (instr_valid) begin
        accept    = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: if (cnt == '0) begin
        wb        = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign instr_ready = (state == IDLE);

  // Operand registers hold between instructions so the ALU output stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_func <= '0;
      rd_q     <= '0;
      op_q     <= '0;
      cnt      <= '0;
    end else if (accept) begin
      alu_a    <= regs[instr_rn];
      alu_b    <= instr_use_imm ? instr_imm : regs[instr_rm];
      alu_func <= instr_op;
      rd_q     <= instr_rd;
      op_q     <= instr_op;
      cnt      <= CNT_INIT;
    end else if (state == WAIT && cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_valid  <= 1'b0;
      done_rd     <= '0;
      done_result <= '0;
      done_err    <= 1'b0;
      flags_q     <= '0;
    end else begin
      done_valid <= wb;
      if (wb) begin
        done_rd     <= rd_q;
        done_result <= alu_result;
        done_err    <= (op_q == OP_ILL);
        if (op_q != OP_ILL) flags_q <= alu_flags;
      end
    end
  end

  // CMP updates flags only; illegal ops touch nothing architectural.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb && op_q != OP_CMP && op_q != OP_ILL) begin
      regs[rd_q] <= alu_result;
    end
  end

  assign dbg_data = regs[dbg_addr];
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: a stand-in ALU drives results, a reference
// model predicts each completion, and a negedge monitor compares them.
module tb_alu_issue_ctrl;
  localparam int W = 32, REG_AW = 4, ALU_LAT = 2, NREG = 16;
  localparam int HALF = 5, PER = 10;

  logic              clk = 1'b0, rst_n = 1'b1;
  logic              instr_valid = 1'b0, instr_ready;
  logic [2:0]        instr_op = '0;
  logic [REG_AW-1:0] instr_rd = '0, instr_rn = '0, instr_rm = '0, dbg_addr = '0;
  logic              instr_use_imm = 1'b0;
  logic [W-1:0]      instr_imm = '0;
  logic [W-1:0]      alu_a, alu_b, alu_result, done_result, dbg_data;
  logic [2:0]        alu_func;
  logic [3:0]        alu_flags, flags_q;
  logic              done_valid, done_err;
  logic [REG_AW-1:0] done_rd;

  always #HALF clk = ~clk;

  alu_issue_ctrl #(.W(W), .REG_AW(REG_AW), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_rd(instr_rd), .instr_rn(instr_rn), .instr_rm(instr_rm),
    .instr_use_imm(instr_use_imm), .instr_imm(instr_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .done_valid(done_valid), .done_rd(done_rd), .done_result(done_result),
    .done_err(done_err), .flags_q(flags_q), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Stand-in ALU: plain arithmetic, flags {N,Z,parity,bit1}, illegal op returns a^const.
  function automatic logic [W-1:0] alu_fn(input logic [2:0] op, input logic [W-1:0] a, b);
    case (op)
      3'd0: return a & b;
      3'd1: return a ^ b;
      3'd2: return a - b;
      3'd3: return a + b;
      3'd4: return a - b;
      3'd5: return a | b;
      3'd6: return a * b;
      default: return a ^ 32'hA5A5_5A5A;
    endcase
  endfunction

  function automatic logic [3:0] flag_fn(input logic [W-1:0] r);
    return {r[W-1], r == '0, ^r, r[1]};
  endfunction

  // ALU_LAT-1 = 1 register stage: new result is visible only at the ALU_LAT-th edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result <= '0;
      alu_flags  <= '0;
    end else begin
      alu_result <= alu_fn(alu_func, alu_a, alu_b);
      alu_flags  <= flag_fn(alu_fn(alu_func, alu_a, alu_b));
    end
  end

  typedef struct {
    logic [REG_AW-1:0] rd;
    logic [W-1:0]      res;
    logic              err;
    logic [3:0]        flags;
    time               t_acc;
  } exp_t;

  exp_t         q[$];
  exp_t         mon_e;
  logic [W-1:0] m_reg [NREG];
  logic [3:0]   m_flags;
  int           errs = 0, checks = 0;
  time          t_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (done_valid) begin
        chk("ready_after_wb", instr_ready, 1);
        if (q.size() == 0) begin
          checks++; errs++;
          $display("FAIL spurious_done: got done_valid=1 expected no pending instr at %0t", $time);
        end else begin
          mon_e = q.pop_front();
          chk("done_rd", done_rd, mon_e.rd);
          chk("done_result", done_result, mon_e.res);
          chk("done_err", done_err, mon_e.err);
          chk("flags_q", flags_q, mon_e.flags);
          chk("latency", $time - mon_e.t_acc, ALU_LAT * PER + HALF);
        end
      end else begin
        chk("ready_level", instr_ready, q.size() == 0);
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_reg[i] = '0;
    m_flags = '0;
    q.delete();
  endtask

  task automatic send(input logic [2:0] op, input logic [REG_AW-1:0] rd, rn, rm,
                      input logic ui, input logic [W-1:0] imm, input bit hold);
    exp_t e;
    logic [W-1:0] a, b;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (instr_ready) begin
        instr_op = op; instr_rd = rd; instr_rn = rn; instr_rm = rm;
        instr_use_imm = ui; instr_imm = imm; instr_valid = 1'b1;
        @(posedge clk);
        a = m_reg[rn];
        b = ui ? imm : m_reg[rm];
        e.res = alu_fn(op, a, b);
        e.err = (op == 3'd7);
        if (op != 3'd7) m_flags = flag_fn(e.res);
        if (op != 3'd7 && op != 3'd4) m_reg[rd] = e.res;
        e.flags = m_flags; e.rd = rd; e.t_acc = $time;
        t_last = $time;
        q.push_back(e);
        return;
      end
      // Not ready: inputs are garbage and must be ignored.
      instr_valid = hold;
      instr_op = 3'($urandom); instr_rd = 4'($urandom); instr_rn = 4'($urandom);
      instr_rm = 4'($urandom); instr_use_imm = 1'($urandom); instr_imm = $urandom;
    end
    checks++; errs++;
    $display("FAIL accept_timeout: got no acceptance expected one within 20 cycles");
  endtask

  task automatic wait_idle();
    @(negedge clk);
    instr_valid = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (q.size() == 0 && instr_ready) return;
      @(negedge clk);
    end
    checks++; errs++;
    $display("FAIL idle_timeout: got %0d pending expected 0", q.size());
  endtask

  task automatic dbg_chk(input string name, input int addr, input logic [W-1:0] val);
    dbg_addr = REG_AW'(addr);
    #1 chk(name, dbg_data, val);
  endtask

  task automatic sweep();
    for (int i = 0; i < NREG; i++) dbg_chk("regfile", i, m_reg[i]);
  endtask

  logic [W-1:0] imm_pick;
  time t0, t1, t2;

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ready", instr_ready, 1);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_func", alu_func, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_flags", flags_q, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sweep();

    // Directed sequence from the block's bring-up list.
    send(3'd3, 1, 0, 0, 1, 5, 0);                 wait_idle();
    dbg_chk("t1_r1", 1, 5);        chk("t1_flags", flags_q, 4'b0000);
    send(3'd2, 2, 1, 0, 1, 5, 0);                 wait_idle();
    dbg_chk("t2_r2", 2, 0);        chk("t2_flags", flags_q, 4'b0100);
    send(3'd1, 5, 0, 0, 1, 32'hFFFF_FFFF, 0);     wait_idle();
    dbg_chk("t3_r5", 5, 32'hFFFF_FFFF);
    send(3'd3, 6, 5, 0, 1, 1, 0);                 wait_idle();
    dbg_chk("t3_r6", 6, 0);        chk("t3_flags", flags_q, 4'b0100);
    send(3'd6, 3, 1, 1, 0, 0, 0);                 wait_idle();
    dbg_chk("t4_r3", 3, 25);
    send(3'd4, 3, 1, 0, 1, 5, 0);                 wait_idle();
    dbg_chk("t4_r3_cmp", 3, 25);

    // Held valid: three back-to-back ADDs, accepted every ALU_LAT+1 cycles.
    send(3'd3, 7, 7, 0, 1, 1, 1); t0 = t_last;
    send(3'd3, 7, 7, 0, 1, 1, 1); t1 = t_last;
    send(3'd3, 7, 7, 0, 1, 1, 1); t2 = t_last;
    wait_idle();
    chk("hold_gap1", t1 - t0, (ALU_LAT + 1) * PER);
    chk("hold_gap2", t2 - t1, (ALU_LAT + 1) * PER);
    dbg_chk("t5_r7", 7, 3);

    // Illegal op: error reported, nothing architectural changes.
    send(3'd7, 1, 1, 0, 1, 32'h1234, 0);          wait_idle();
    sweep();

    // Reset while waiting on the ALU.
    send(3'd3, 9, 1, 0, 1, 77, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_ready", instr_ready, 1);
    chk("midrst_alu_a", alu_a, 0);
    chk("midrst_alu_b", alu_b, 0);
    chk("midrst_alu_func", alu_func, 0);
    chk("midrst_flags", flags_q, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_done", done_valid, 0);
    end
    instr_valid = 1'b0;
    rst_n = 1'b1;
    sweep();

    // Randomized stream, held and dropped valid mixed.
    for (int k = 0; k < 80; k++) begin
      case ($urandom_range(0, 4))
        0: imm_pick = '0;
        1: imm_pick = 32'hFFFF_FFFF;
        2: imm_pick = 32'h8000_0000;
        3: imm_pick = 1;
        default: imm_pick = $urandom;
      endcase
      send(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 4'($urandom),
           1'($urandom), imm_pick, 1'($urandom));
      if ($urandom_range(0, 9) == 0) begin
        wait_idle();
        sweep();
      end
    end
    wait_idle();
    sweep();
    chk("drain", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
